// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and one-cycle key strobe.
//   clk    : single clock, rising edge
//   reset  : asynchronous active-high reset
//   cols   : column sense lines, active-low, asynchronous to clk
//   rows   : row drives, active-low, exactly one row low at any time
//   s      : hex code of the last accepted key, held until the next one
//   en     : one-cycle strobe marking a new s value
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] s,
  output logic       en
);

  localparam int unsigned DW_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      sync1_q, csync_q;
  logic [1:0]      ridx_q, ridx_d;
  logic [1:0]      cidx_q, cidx_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic [3:0]      rows_q, rows_d;
  logic [3:0]      s_q, s_d;
  logic            en_q, en_d;

  // Row-major key map: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = E 0 F D
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index low column; only called when at least one column is low
  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    logic [1:0] idx;
    if (!c[0])      idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  // Two-flop column synchronizer; idle (all high) out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hF;
      csync_q <= 4'hF;
    end else begin
      sync1_q <= cols;
      csync_q <= sync1_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SCAN;
      ridx_q  <= 2'd0;
      cidx_q  <= 2'd0;
      dwell_q <= '0;
      cnt_q   <= '0;
      rows_q  <= 4'b1110;
      s_q     <= 4'h0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ridx_q  <= ridx_d;
      cidx_q  <= cidx_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
      s_q     <= s_d;
      en_q    <= en_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    ridx_d  = ridx_q;
    cidx_d  = cidx_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    en_d    = 1'b0;

    case (state_q)
      // Dwell on each row long enough for the synchronizer to see its columns
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (csync_q == 4'hF) begin
            ridx_d = ridx_q + 2'd1;
          end else begin
            cidx_d  = lowest_low(csync_q);
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end

      // Any high sample on the latched column aborts; the counter never wraps
      ST_DEBOUNCE: begin
        if (csync_q[cidx_q]) begin
          dwell_d = '0;
          state_d = ST_SCAN;
        end else if (cnt_q == DB_LAST) begin
          en_d    = 1'b1;
          s_d     = key_code(ridx_q, cidx_q);
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end

      // Only the accepted key's column matters while held
      ST_HELD: begin
        if (csync_q[cidx_q]) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      // Resume scanning on the next row so a still-held neighbour is found in order
      ST_RELEASE: begin
        if (!csync_q[cidx_q]) begin
          state_d = ST_HELD;
        end else if (cnt_q == DB_LAST) begin
          ridx_d  = ridx_q + 2'd1;
          dwell_d = '0;
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end

      default: state_d = ST_SCAN;
    endcase

    rows_d = ~(4'b0001 << ridx_d);
  end

  assign rows = rows_q;
  assign s    = s_q;
  assign en   = en_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a resistive keypad model.
module tb_keypad_scanner;

  localparam int LAT_MAX = 27;

  logic        clk;
  logic        reset;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [3:0]  s;
  logic        en;
  logic [15:0] keys;   // keys[{row,col}] = 1 while that key is pressed

  int          checks;
  int          failures;
  int          en_cnt;
  logic        en_prev;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[16];

  keypad_scanner dut (
    .clk   (clk),
    .reset (reset),
    .cols  (cols),
    .rows  (rows),
    .s     (s),
    .en    (en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its column to its row while that row is driven low
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4'(r * 4 + c)] && !rows[2'(r)]) cols[2'(c)] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock cycle, sampled on the falling edge, with per-cycle invariants
  task automatic step();
    @(negedge clk);
    chk("rows_one_low", 32'($countones(~rows)), 32'd1);
    if (!reset) begin
      chk("en_not_consecutive", 32'(en && en_prev), 32'd0);
      if (en) en_cnt++;
      en_prev = en;
    end else begin
      en_prev = 1'b0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Returns the number of cycles until en is seen high, or 0 if the budget expires
  task automatic wait_en(input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (en) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic chk_scanning(input string name);
    logic [3:0] r0;
    r0 = rows;
    steps(4);
    chk(name, 32'(rows != r0), 32'd1);
  endtask

  int         lat;
  int         base;
  logic [3:0] s_before;

  initial begin
    vecs[0]  = '{r: 2'd0, c: 2'd0, code: 4'h1};
    vecs[1]  = '{r: 2'd0, c: 2'd1, code: 4'h2};
    vecs[2]  = '{r: 2'd0, c: 2'd2, code: 4'h3};
    vecs[3]  = '{r: 2'd0, c: 2'd3, code: 4'hA};
    vecs[4]  = '{r: 2'd1, c: 2'd0, code: 4'h4};
    vecs[5]  = '{r: 2'd1, c: 2'd1, code: 4'h5};
    vecs[6]  = '{r: 2'd1, c: 2'd2, code: 4'h6};
    vecs[7]  = '{r: 2'd1, c: 2'd3, code: 4'hB};
    vecs[8]  = '{r: 2'd2, c: 2'd0, code: 4'h7};
    vecs[9]  = '{r: 2'd2, c: 2'd1, code: 4'h8};
    vecs[10] = '{r: 2'd2, c: 2'd2, code: 4'h9};
    vecs[11] = '{r: 2'd2, c: 2'd3, code: 4'hC};
    vecs[12] = '{r: 2'd3, c: 2'd0, code: 4'hE};
    vecs[13] = '{r: 2'd3, c: 2'd1, code: 4'h0};
    vecs[14] = '{r: 2'd3, c: 2'd2, code: 4'hF};
    vecs[15] = '{r: 2'd3, c: 2'd3, code: 4'hD};

    checks   = 0;
    failures = 0;
    en_cnt   = 0;
    en_prev  = 1'b0;
    keys     = 16'h0;
    reset    = 1'b1;

    // Reset values
    steps(3);
    chk("reset_rows", 32'(rows), 32'hE);
    chk("reset_s", 32'(s), 32'h0);
    chk("reset_en", 32'(en), 32'h0);
    reset = 1'b0;
    steps(2);

    // Every key: latency bound, code, single strobe while held, none on release
    for (int k = 0; k < 16; k++) begin
      base = en_cnt;
      keys[{vecs[k].r, vecs[k].c}] = 1'b1;
      wait_en(LAT_MAX, lat);
      chk($sformatf("key%0d_latency_ok", k), 32'(lat > 0), 32'd1);
      chk($sformatf("key%0d_code", k), 32'(s), 32'(vecs[k].code));
      steps(20);
      chk($sformatf("key%0d_pulses_held", k), 32'(en_cnt - base), 32'd1);
      keys = 16'h0;
      steps(20);
      chk($sformatf("key%0d_pulses_released", k), 32'(en_cnt - base), 32'd1);
    end

    // Clean long press of key (1,1)
    base = en_cnt;
    keys[{2'd1, 2'd1}] = 1'b1;
    wait_en(LAT_MAX, lat);
    chk("long5_latency_ok", 32'(lat > 0), 32'd1);
    chk("long5_code", 32'(s), 32'h5);
    steps(200 - lat);
    chk("long5_pulses", 32'(en_cnt - base), 32'd1);
    keys = 16'h0;
    steps(20);
    chk_scanning("long5_rows_resume");
    chk("long5_pulses_after", 32'(en_cnt - base), 32'd1);

    // Bouncing key (2,2): 5 low / 3 high never reaches 8 stable cycles
    base     = en_cnt;
    s_before = s;
    for (int i = 0; i < 100; i++) begin
      keys[{2'd2, 2'd2}] = ((i % 8) < 5);
      step();
    end
    chk("bounce_no_pulse", 32'(en_cnt - base), 32'd0);
    chk("bounce_s_unchanged", 32'(s), 32'(s_before));
    keys[{2'd2, 2'd2}] = 1'b1;
    wait_en(LAT_MAX, lat);
    chk("bounce_stable_latency_ok", 32'(lat > 0), 32'd1);
    chk("bounce_stable_code", 32'(s), 32'h9);
    steps(20);
    chk("bounce_stable_pulses", 32'(en_cnt - base), 32'd1);
    keys = 16'h0;
    steps(20);

    // Two keys on row 0: lowest column wins, the other follows after release
    base = en_cnt;
    keys[{2'd0, 2'd1}] = 1'b1;
    keys[{2'd0, 2'd2}] = 1'b1;
    wait_en(LAT_MAX, lat);
    chk("dual_first_latency_ok", 32'(lat > 0), 32'd1);
    chk("dual_first_code", 32'(s), 32'h2);
    steps(30);
    chk("dual_first_pulses", 32'(en_cnt - base), 32'd1);
    keys[{2'd0, 2'd1}] = 1'b0;
    wait_en(60, lat);
    chk("dual_second_seen", 32'(lat > 0), 32'd1);
    chk("dual_second_code", 32'(s), 32'h3);
    steps(20);
    chk("dual_total_pulses", 32'(en_cnt - base), 32'd2);
    keys = 16'h0;
    steps(20);

    // Key (3,0) with a bouncy release, then pressed again
    base = en_cnt;
    keys[{2'd3, 2'd0}] = 1'b1;
    wait_en(LAT_MAX, lat);
    chk("rebounce_first_code", 32'(s), 32'hE);
    steps(20);
    for (int i = 0; i < 4; i++) begin
      keys[{2'd3, 2'd0}] = i[0];
      step();
    end
    keys = 16'h0;
    steps(30);
    chk("rebounce_after_release", 32'(en_cnt - base), 32'd1);
    keys[{2'd3, 2'd0}] = 1'b1;
    wait_en(LAT_MAX, lat);
    chk("rebounce_second_latency_ok", 32'(lat > 0), 32'd1);
    chk("rebounce_second_code", 32'(s), 32'hE);
    steps(20);
    chk("rebounce_total_pulses", 32'(en_cnt - base), 32'd2);
    keys = 16'h0;
    steps(20);

    // Reset while holding key (3,3), key still held afterwards
    keys[{2'd3, 2'd3}] = 1'b1;
    wait_en(LAT_MAX, lat);
    chk("held_reset_first_code", 32'(s), 32'hD);
    steps(10);
    #1 reset = 1'b1;
    #1;
    chk("held_reset_rows", 32'(rows), 32'hE);
    chk("held_reset_s", 32'(s), 32'h0);
    chk("held_reset_en", 32'(en), 32'h0);
    step();
    reset = 1'b0;
    base = en_cnt;
    wait_en(LAT_MAX, lat);
    chk("held_reset_fresh_latency_ok", 32'(lat > 0), 32'd1);
    chk("held_reset_fresh_code", 32'(s), 32'hD);
    steps(20);
    chk("held_reset_fresh_pulses", 32'(en_cnt - base), 32'd1);
    keys = 16'h0;
    steps(20);

    // Reset landing inside the strobe cycle cuts en immediately
    keys[{2'd2, 2'd1}] = 1'b1;
    wait_en(LAT_MAX, lat);
    chk("en_reset_strobe_seen", 32'(en), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("en_reset_en", 32'(en), 32'h0);
    chk("en_reset_s", 32'(s), 32'h0);
    chk("en_reset_rows", 32'(rows), 32'hE);
    keys = 16'h0;
    step();
    reset = 1'b0;
    steps(8);
    chk("en_reset_rows_restart", 32'(rows), 32'hB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clk cycles each row is driven before its columns are sampled; legal range 3..1024.
REQ-002 Parameter DEBOUNCE, default 8: consecutive stable clk cycles required to accept a press or a release; legal range 1..2^20.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cols  input  4  keypad column lines, active-low with external pull-ups, asynchronous to clk.
REQ-006 rows  output  4  keypad row drives, active-low, exactly one bit low at all times.
REQ-007 s  output  4  hex code of the last accepted key, held until the next accepted key.
REQ-008 en  output  1  one-cycle strobe marking a new s value; the display controller takes this as its digit-enable.

Function
REQ-009 cols SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (csync).
REQ-010 The FSM SHALL have states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-011 In SCAN, rows SHALL equal ~(1<<ridx); a dwell counter counts 0..SCAN_DIV-1 per row.
- At dwell count SCAN_DIV-1 with csync==4'hF: ridx advances, wrapping 3->0, and the dwell counter clears.
- At dwell count SCAN_DIV-1 with csync!=4'hF: latch ridx and the lowest-index low column (cidx), clear the debounce counter, enter DEBOUNCE.
REQ-012 In DEBOUNCE, rows SHALL stay on the latched row.
- csync[cidx]==1 on any cycle: return to SCAN on the same row with the dwell counter cleared, no strobe.
- csync[cidx]==0 on DEBOUNCE consecutive cycles: on the next cycle drive en=1 with s=code(ridx,cidx), and enter HELD.
REQ-013 Key map, row-major, columns 0..3:
- row0: 1 2 3 A
- row1: 4 5 6 B
- row2: 7 8 9 C
- row3: E 0 F D
REQ-014 en SHALL be high exactly one cycle per accepted press and SHALL never be asserted on consecutive cycles.
REQ-015 In HELD, rows SHALL stay on the latched row; csync[cidx]==1 enters RELEASE with the counter cleared; other columns are ignored.
REQ-016 In RELEASE:
- csync[cidx]==0: return to HELD.
- DEBOUNCE consecutive high cycles: enter SCAN with ridx advanced by one (wrapping) and the dwell counter cleared.
REQ-017 Simultaneous keys SHALL produce one strobe, for the first key detected in scan order, lowest column first within a row; a second key pressed while the first is held SHALL generate no strobe.
REQ-018 Counters SHALL saturate or clear, and never wrap into false acceptance; widths sized by $clog2 of their parameters.
REQ-019 Worst-case press-to-en latency SHALL be at most 2 + 4*SCAN_DIV + DEBOUNCE + 1 cycles.

Reset
REQ-020 While reset is high:
- rows=4'b1110, s=4'h0, en=0
- state=SCAN, ridx=0, all counters=0
- synchronizer flops=4'hF
REQ-021 Reset asserted mid-operation (any state, including the en cycle) SHALL take effect immediately and asynchronously; en falls without completing the strobe.
REQ-022 After reset deasserts, scanning SHALL restart at row 0 on the first rising edge.

Verification (defaults SCAN_DIV=4, DEBOUNCE=8; the bench keypad model pulls cols[c] low while rows[r] is low and key (r,c) is pressed)
REQ-023 Press key (1,1) cleanly for 200 cycles, then release -> exactly one en pulse with s=4'h5, within 27 cycles of press; rows resume cycling after release.
REQ-024 Bounce key (2,2) low 5 cycles / high 3 cycles repeatedly for 100 cycles -> no en pulse, s unchanged; a stable press after that -> one pulse with s=4'h9.
REQ-025 Press (0,1) and (0,2) together -> one pulse with s=4'h2; release (0,1) while still holding (0,2) -> after release debounce, one pulse with s=4'h3.
REQ-026 Press (3,0), then release with 4-cycle bounce, then re-press -> exactly two pulses, both s=4'hE.
REQ-027 Assert reset for 1 cycle while in HELD on key (3,3) -> immediately rows=4'b1110, s=0, en=0; key still held after reset -> one fresh pulse with s=4'hD.
REQ-028 Check every cycle (assertion): rows always has exactly one zero bit; en is never high on two consecutive cycles.
